// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO pair.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module mul_div_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d, a_raw_q, a_raw_d;
  logic               sgn_q, sgn_d, rneg_q, rneg_d, bz_q, bz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d;

  // operand magnitudes for signed ops (op[0]=0 means signed)
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // multiply step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, fast_prod, prod;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign mul_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
  assign fast_prod = {{WIDTH{1'b0}}, ma_q} * {{WIDTH{1'b0}}, mb_q};
  assign prod      = FAST_MUL ? fast_prod : mul_nxt;

  // divide step: acc = {remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mb_q};
  assign rem_nxt   = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_nxt   = {rem_nxt, acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};

  logic last;
  assign last = (cnt_q == CW'(WIDTH - 1)) || (FAST_MUL && !is_div_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    a_raw_d  = a_raw_q;
    sgn_d    = sgn_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            state_d  = CALC;
            cnt_d    = '0;
            is_div_d = op[1];
            ma_d     = a_mag;
            mb_d     = b_mag;
            a_raw_d  = a;
            sgn_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            bz_d     = (b == '0);
            acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            dz_d     = 1'b0;
          end else if (op == 3'b100) begin
            hi_d = a;
          end else if (op == 3'b101) begin
            lo_d = a;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = is_div_q ? div_nxt : mul_nxt;
        if (last) begin
          state_d = FIN;
          if (!is_div_q) begin
            {hi_d, lo_d} = sgn_q ? -prod : prod;
          end else if (bz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            lo_d = sgn_q  ? -div_nxt[WIDTH-1:0]       : div_nxt[WIDTH-1:0];
            hi_d = rneg_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      a_raw_q  <= '0;
      sgn_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      a_raw_q  <= a_raw_d;
      sgn_q    <= sgn_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: iterative instance plus a FAST_MUL instance.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_f = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero, busy_f, done_f, div_zero_f;
  logic [31:0] hi, lo, hi_f, lo_f;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));

  mul_div_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start_f), .op(op), .a(a), .b(b),
    .busy(busy_f), .done(done_f), .div_zero(div_zero_f), .hi(hi_f), .lo(lo_f));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // issue one op on the iterative unit; optionally inject an MTHI start mid-CALC
  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input int inj, input logic [31:0] hold_hi,
                        output int lat, output int nbusy);
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1;
    lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (inj > 0 && lat == inj + 1) chk("mid_hi_stable", hi, hold_hi);
      if (lat == inj) begin
        start = 1'b1; op = 3'b100; a = 32'hDEADBEEF; b = 32'h0;
      end
      if (busy) nbusy++;
    end while (!done && lat < 100);
    start = 1'b0;
  endtask

  initial begin
    int lat, nb;
    bit saw_done;

    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_dz", 32'(div_zero), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, lat, nb);
    chk("multu_lat", 32'(lat), 32'd33);
    chk("multu_busy", 32'(nb), 32'd33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'h0);
    chk("busy_after", 32'(busy), 32'h0);

    run_op(3'b000, 32'hFFFFFFF9, 32'd3, 0, 32'h0, lat, nb);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    run_op(3'b010, 32'hFFFFFFF9, 32'd2, 0, 32'h0, lat, nb);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(3'b011, 32'd100, 32'd7, 0, 32'h0, lat, nb);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_dz", 32'(div_zero), 32'h0);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, lat, nb);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_dz", 32'(div_zero), 32'h0);

    run_op(3'b011, 32'd5, 32'd0, 0, 32'h0, lat, nb);
    chk("dz_lat", 32'(lat), 32'd33);
    chk("dz_hi", hi, 32'd5);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_flag", 32'(div_zero), 32'h1);

    run_op(3'b001, 32'd3, 32'd5, 0, 32'h0, lat, nb);
    chk("dz_clear", 32'(div_zero), 32'h0);
    chk("m35_lo", lo, 32'd15);

    @(negedge clk);
    op = 3'b100; a = 32'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'h0);
    chk("mthi_done", 32'(done), 32'h0);
    op = 3'b101; a = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi", hi, 32'h1234);

    run_op(3'b001, 32'd6, 32'd7, 5, 32'h1234, lat, nb);
    chk("inj_lat", 32'(lat), 32'd33);
    chk("inj_hi", hi, 32'h0);
    chk("inj_lo", lo, 32'd42);

    @(negedge clk);
    op = 3'b110; a = 32'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rsv_busy", 32'(busy), 32'h0);
    chk("rsv_hi", hi, 32'h0);
    chk("rsv_lo", lo, 32'd42);

    @(negedge clk);
    op = 3'b001; a = 32'h10000; b = 32'h10000; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    lat = 1;
    while (!done_f && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("fast_lat", 32'(lat), 32'd2);
    chk("fast_hi", hi_f, 32'h1);
    chk("fast_lo", lo_f, 32'h0);

    @(negedge clk);
    op = 3'b100; a = 32'hAAAA; start = 1'b1;
    @(negedge clk);
    op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("arst_nodone", 32'(saw_done), 32'h0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
